// File: rtl/gpr_wb_sequencer.sv
// gpr_wb_sequencer: writeback-side driver for the single-write-port register
// file. Each accepted bundle expands into up to three register writes
// (jal link, overflow flag, main result). The writes wait in a small FIFO
// and leave it one per clock on RegWr/rw/busW. Decode can query the writes
// that are still pending so it can forward their data.
// Optional feature macro: GPR_WB_OVF_EN. When it is defined, 'over' enqueues
// the OVF_REG <- 1 write. When it is undefined, 'over' is ignored and a
// bundle carries at most two writes.
module gpr_wb_sequencer #(
  parameter int          DEPTH    = 4,
  parameter logic [4:0]  LINK_REG = 5'd31,
  parameter logic [4:0]  OVF_REG  = 5'd30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic        wb_regwr,
  input  logic [4:0]  wb_rw,
  input  logic [31:0] wb_data,
  input  logic        jal_sel,
  input  logic [31:0] jal_pc,
  input  logic        over,
  output logic        RegWr,
  output logic [4:0]  rw,
  output logic [31:0] busW,
  input  logic [4:0]  q_addr,
  output logic        q_hit,
  output logic [31:0] q_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef GPR_WB_OVF_EN
  localparam int  MAX_W  = 3;
  localparam bit  OVF_EN = 1'b1;
`else
  localparam int  MAX_W  = 2;
  localparam bit  OVF_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_W_C = CNT_W'(MAX_W);

  // Queue storage and bookkeeping.
  logic [4:0]       mem_addr [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  // Writes that the current bundle expands into, already packed oldest-first.
  logic [4:0]  new_addr [4];
  logic [31:0] new_data [4];
  logic [1:0]  n_new;

  logic accept, pop;
  logic over_used;

  assign over_used = OVF_EN & over;
  assign wb_ready  = (DEPTH_C - count) >= MAX_W_C;
  assign accept    = wb_valid & wb_ready;
  assign pop       = (count != '0);

  // Expand the bundle into packed slots, dropping writes to register 0.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
    n_new    = '0;
    new_addr = '{default: '0};
    new_data = '{default: '0};
    if (jal_sel && LINK_REG != 5'd0) begin
      new_addr[n_new] = LINK_REG;
      new_data[n_new] = jal_pc;
      n_new           = 2'(n_new + 2'd1);
    end
    if (over_used && OVF_REG != 5'd0) begin
      new_addr[n_new] = OVF_REG;
      new_data[n_new] = 32'd1;
      n_new           = 2'(n_new + 2'd1);
    end
    if (wb_regwr && wb_rw != 5'd0) begin
      new_addr[n_new] = wb_rw;
      new_data[n_new] = wb_data;
      n_new           = 2'(n_new + 2'd1);
    end
  end

  // Write the accepted entries into the storage array at the tail.
  // NOTE: the storage has no reset, because count and the pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int k = 0; k < 3; k++) begin
        if (2'(k) < n_new) begin
          mem_addr[tail + PTR_W'(k)] <= new_addr[k];
          mem_data[tail + PTR_W'(k)] <= new_data[k];
        end
      end
    end
  end

  // Update the pointers and the occupancy count. Accept and pop may happen in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) head <= head + PTR_W'(1);
      if (accept) tail <= tail + PTR_W'(n_new);
      count <= count + (accept ? CNT_W'(n_new) : '0) - CNT_W'(pop);
    end
  end

  // Output stage: pop the head into the register-file write port, or idle and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWr <= 1'b0;
      rw    <= '0;
      busW  <= '0;
    end else if (pop) begin
      RegWr <= 1'b1;
      rw    <= mem_addr[head];
      busW  <= mem_data[head];
    end else begin
      RegWr <= 1'b0;
    end
  end

  // Forwarding: the youngest live queue entry wins, then the output stage.
  always_comb begin
    logic [PTR_W-1:0] idx;
    q_hit  = 1'b0;
    q_data = '0;
    idx    = '0;
    if (q_addr != 5'd0) begin
      if (RegWr && rw == q_addr) begin
        q_hit  = 1'b1;
        q_data = busW;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PTR_W'(i);
        if (CNT_W'(i) < count && mem_addr[idx] == q_addr) begin
          q_hit  = 1'b1;
          q_data = mem_data[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_sequencer.sv
// Testbench for gpr_wb_sequencer. Directed steps cover reset, bundle expansion,
// dropped writes, back-pressure and reset while writes are pending. A
// randomized phase follows. Every comparison is made against a queue-based
// reference model of pending register writes.
module tb_gpr_wb_sequencer;

  localparam int DEPTH = 4;
`ifdef GPR_WB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_ready, wb_regwr, jal_sel, over;
  logic [4:0]  wb_rw, rw, q_addr;
  logic [31:0] wb_data, jal_pc, busW, q_data;
  logic        RegWr, q_hit;

  gpr_wb_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_regwr(wb_regwr), .wb_rw(wb_rw), .wb_data(wb_data),
    .jal_sel(jal_sel), .jal_pc(jal_pc), .over(over),
    .RegWr(RegWr), .rw(rw), .busW(busW),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the list of writes not yet issued, plus the write port.
  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t         mq[$];
  logic        m_regwr = 1'b0;
  logic [4:0]  m_rw    = '0;
  logic [31:0] m_busw  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready();
    int max_w;
    max_w = OVF_EN ? 3 : 2;
    return (DEPTH - mq.size()) >= max_w;
  endfunction

  task automatic model_fwd(input logic [4:0] q, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (q != 5'd0) begin
      if (m_regwr && m_rw == q) begin h = 1'b1; d = m_busw; end
      foreach (mq[i]) if (mq[i].a == q) begin h = 1'b1; d = mq[i].d; end
    end
  endtask

  // One clock: check the combinational outputs mid-cycle, advance the model, then check the write port.
  task automatic cycle();
    logic        h, acc;
    logic [31:0] d;
    #3;
    acc = wb_valid && model_ready() && !rst;
    if (!rst) begin
      model_fwd(q_addr, h, d);
      check("wb_ready", 32'(wb_ready), 32'(model_ready()));
      check("q_hit",    32'(q_hit),    32'(h));
      check("q_data",   q_data,        d);
    end
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_regwr = 1'b0; m_rw = '0; m_busw = '0;
    end else begin
      if (mq.size() > 0) begin
        wr_t w;
        w = mq.pop_front();
        m_regwr = 1'b1; m_rw = w.a; m_busw = w.d;
      end else begin
        m_regwr = 1'b0;
      end
      if (acc) begin
        if (jal_sel) mq.push_back({5'd31, jal_pc});
        if (OVF_EN && over) mq.push_back({5'd30, 32'd1});
        if (wb_regwr && wb_rw != 5'd0) mq.push_back({wb_rw, wb_data});
      end
    end
    #1;
    check("RegWr", 32'(RegWr), 32'(m_regwr));
    check("rw",    32'(rw),    32'(m_rw));
    check("busW",  busW,       m_busw);
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_regwr = 1'b0; wb_rw = '0; wb_data = '0;
    jal_sel = 1'b0; jal_pc = '0; over = 1'b0;
  endtask

  task automatic bundle(input logic j, input logic [31:0] pc, input logic ov,
                        input logic r, input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1'b1; jal_sel = j; jal_pc = pc; over = ov;
    wb_regwr = r; wb_rw = a; wb_data = d;
  endtask

  initial begin
    idle_inputs();
    q_addr = '0;
    rst = 1'b1;

    // Reset
    cycle();
    cycle();
    check("rst_RegWr", 32'(RegWr), 32'd0);
    check("rst_busW", busW, 32'd0);
    rst = 1'b0;
    q_addr = 5'd8;
    cycle();

    // 1: single main write
    bundle(1'b0, '0, 1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF);
    cycle();
    idle_inputs();
    cycle();
    check("t1_RegWr", 32'(RegWr), 32'd1);
    check("t1_rw", 32'(rw), 32'd8);
    check("t1_busW", busW, 32'hDEAD_BEEF);
    cycle();
    check("t1_idle", 32'(RegWr), 32'd0);

    // 2: jal, over and main from one bundle
    q_addr = 5'd31;
    bundle(1'b1, 32'h0040_0010, 1'b1, 1'b1, 5'd9, 32'd5);
    cycle();
    idle_inputs();
    repeat (4) cycle();

    // 3: a bundle that carries only a write to register 0
    q_addr = 5'd0;
    bundle(1'b0, '0, 1'b0, 1'b1, 5'd0, 32'h1234);
    cycle();
    idle_inputs();
    cycle();
    check("t3_RegWr", 32'(RegWr), 32'd0);
    check("t3_q_hit", 32'(q_hit), 32'd0);

    // 4: back-to-back full bundles under back-pressure
    q_addr = 5'd31;
    for (int i = 0; i < 6; i++) begin
      bundle(1'b1, 32'h1000_0000 + 32'(i), 1'b1, 1'b1, 5'd12, 32'hA0 + 32'(i));
      cycle();
    end
    idle_inputs();
    repeat (8) cycle();

    // 5: reset while writes are pending
    bundle(1'b1, 32'h0BAD_0001, 1'b1, 1'b1, 5'd7, 32'h77);
    cycle();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #3;
    check("t5_ready", 32'(wb_ready), 32'd1);
    check("t5_q_hit", 32'(q_hit), 32'd0);
    check("t5_RegWr", 32'(RegWr), 32'd0);
    @(posedge clk); #1;
    check("t5_stale", 32'(RegWr), 32'd0);

    // 6: overflow flag together with a main write to register 3
    q_addr = 5'd30;
    bundle(1'b0, '0, 1'b1, 1'b1, 5'd3, 32'h33);
    cycle();
    idle_inputs();
    cycle();
    check("t6_rw", 32'(rw), OVF_EN ? 32'd30 : 32'd3);
    repeat (2) cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] pick [6];
      pick = '{5'd0, 5'd30, 5'd31, 5'd1, 5'd2, 5'd3};
      rst      = ($urandom_range(0, 59) == 0);
      wb_valid = $urandom_range(0, 1);
      wb_regwr = $urandom_range(0, 1);
      wb_rw    = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 5)] : 5'($urandom);
      wb_data  = $urandom;
      jal_sel  = $urandom_range(0, 1);
      jal_pc   = $urandom;
      over     = $urandom_range(0, 1);
      q_addr   = pick[$urandom_range(0, 5)];
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    repeat (6) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
